alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 129 ++++++++++++
 tb/tb_alu_seq.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequencer wrapping an external combinational ALU: request handshake, one execute cycle,
// response handshake. Define ALU_SEQ_OPCNT_EN to add the 16-bit completed-operation counter.
module alu_seq #(
    parameter int unsigned W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic [W-1:0] req_x_i,
    input  logic [W-1:0] req_y_i,
    input  logic [2:0]   req_op_i,
    output logic [W-1:0] x_o,
    output logic [W-1:0] y_o,
    output logic [2:0]   op_o,
    input  logic [W-1:0] r_i,
    input  logic         fz_i,
    input  logic         fc_i,
    output logic         rsp_valid_o,
    input  logic         rsp_ready_i,
    output logic [W-1:0] rsp_r_o,
    output logic         rsp_fz_o,
    output logic         rsp_fc_o,
`ifdef ALU_SEQ_OPCNT_EN
    output logic [15:0]  opcnt_o,
`endif
    output logic         flag_z_o,
    output logic         flag_c_o
);

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e state_q, state_d;

    logic [W-1:0] x_q, y_q;
    logic [2:0]   op_q;
    logic [W-1:0] rsp_r_q;
    logic         rsp_fz_q, rsp_fc_q;
    logic         flag_z_q, flag_c_q;

    logic accept, capture, done;

    always_comb begin
        state_d     = state_q;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        done        = 1'b0;
        case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept  = 1'b1;
                    state_d = StExec;
                end
            end
            StExec: begin
                capture = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) begin
                    done    = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            x_q      <= '0;
            y_q      <= '0;
            op_q     <= '0;
            rsp_r_q  <= '0;
            rsp_fz_q <= 1'b0;
            rsp_fc_q <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q  <= req_x_i;
                y_q  <= req_y_i;
                op_q <= req_op_i;
            end
            // Flags follow the ALU only at the execute capture.
            if (capture) begin
                rsp_r_q  <= r_i;
                rsp_fz_q <= fz_i;
                rsp_fc_q <= fc_i;
                flag_z_q <= fz_i;
                flag_c_q <= fc_i;
            end
        end
    end

`ifdef ALU_SEQ_OPCNT_EN
    logic [15:0] opcnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            opcnt_q <= '0;
        end else if (done) begin
            opcnt_q <= opcnt_q + 16'd1;
        end
    end

    assign opcnt_o = opcnt_q;
`endif

    assign x_o      = x_q;
    assign y_o      = y_q;
    assign op_o     = op_q;
    assign rsp_r_o  = rsp_r_q;
    assign rsp_fz_o = rsp_fz_q;
    assign rsp_fc_o = rsp_fc_q;
    assign flag_z_o = flag_z_q;
    assign flag_c_o = flag_c_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: directed vector table, reset corner cases, then random operations
// checked against an arithmetic reference model. Connects opcnt_o when ALU_SEQ_OPCNT_EN is set.
module tb_alu_seq;

    localparam int unsigned W = 8;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         req_valid_i;
    logic         req_ready_o;
    logic [W-1:0] req_x_i, req_y_i;
    logic [2:0]   req_op_i;
    logic [W-1:0] x_o, y_o;
    logic [2:0]   op_o;
    logic [W-1:0] r_i;
    logic         fz_i, fc_i;
    logic         rsp_valid_o;
    logic         rsp_ready_i;
    logic [W-1:0] rsp_r_o;
    logic         rsp_fz_o, rsp_fc_o;
    logic         flag_z_o, flag_c_o;
`ifdef ALU_SEQ_OPCNT_EN
    logic [15:0]  opcnt_o;
    int           ops_done = 0;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic flag_z_m = 1'b0;
    logic flag_c_m = 1'b0;

    alu_seq #(.W(W)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_x_i     (req_x_i),
        .req_y_i     (req_y_i),
        .req_op_i    (req_op_i),
        .x_o         (x_o),
        .y_o         (y_o),
        .op_o        (op_o),
        .r_i         (r_i),
        .fz_i        (fz_i),
        .fc_i        (fc_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_r_o     (rsp_r_o),
        .rsp_fz_o    (rsp_fz_o),
        .rsp_fc_o    (rsp_fc_o),
`ifdef ALU_SEQ_OPCNT_EN
        .opcnt_o     (opcnt_o),
`endif
        .flag_z_o    (flag_z_o),
        .flag_c_o    (flag_c_o)
    );

    always #5 clk_i = ~clk_i;

    // External combinational ALU: ADD, SUB (carry = borrow), anything else passes x through.
    always_comb begin
        r_i  = x_o;
        fc_i = 1'b0;
        case (op_o)
            3'b000: {fc_i, r_i} = {1'b0, x_o} + {1'b0, y_o};
            3'b001: begin
                r_i  = x_o - y_o;
                fc_i = (x_o < y_o);
            end
            default: ;
        endcase
        fz_i = (r_i == '0);
    end

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [2:0]   op;
        int           hold;
        logic [W-1:0] r;
        logic         fz;
        logic         fc;
    } vec_t;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the operation's definition.
    task automatic ref_model(input int x, input int y, input int op,
                             output logic [W-1:0] r, output logic fz, output logic fc);
        int m;
        int res;
        m = 1 << W;
        if (op == 0) begin
            res = x + y;
            fc  = (res >= m);
        end else if (op == 1) begin
            res = x - y;
            fc  = (x < y);
        end else begin
            res = x;
            fc  = 1'b0;
        end
        res = ((res % m) + m) % m;
        r   = res[W-1:0];
        fz  = (res == 0);
    endtask

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic [2:0] op,
                         input int hold, input logic [W-1:0] er, input logic efz,
                         input logic efc);
        int waited = 0;
        while (!req_ready_o && waited < 10) begin
            tick();
            waited++;
        end
        check("req_ready_before_req", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        req_x_i     = x;
        req_y_i     = y;
        req_op_i    = op;
        rsp_ready_i = 1'b0;
        tick();
        // Keep presenting different operands: must be ignored outside IDLE.
        req_x_i  = ~x;
        req_y_i  = ~y;
        req_op_i = op ^ 3'b001;
        check("exec_req_ready", {31'd0, req_ready_o}, 32'd0);
        check("exec_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("exec_x_o", {24'd0, x_o}, {24'd0, x});
        check("exec_y_o", {24'd0, y_o}, {24'd0, y});
        check("exec_op_o", {29'd0, op_o}, {29'd0, op});
        tick();
        flag_z_m = efz;
        flag_c_m = efc;
        check("resp_valid", {31'd0, rsp_valid_o}, 32'd1);
        check("resp_r", {24'd0, rsp_r_o}, {24'd0, er});
        check("resp_fz", {31'd0, rsp_fz_o}, {31'd0, efz});
        check("resp_fc", {31'd0, rsp_fc_o}, {31'd0, efc});
        check("resp_flag_z", {31'd0, flag_z_o}, {31'd0, flag_z_m});
        check("resp_flag_c", {31'd0, flag_c_o}, {31'd0, flag_c_m});
        for (int i = 0; i < hold; i++) begin
            tick();
            check("stall_valid", {31'd0, rsp_valid_o}, 32'd1);
            check("stall_req_ready", {31'd0, req_ready_o}, 32'd0);
            check("stall_rsp", {23'd0, rsp_r_o, rsp_fz_o}, {23'd0, er, efz});
            check("stall_x_o", {24'd0, x_o}, {24'd0, x});
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b0;
`ifdef ALU_SEQ_OPCNT_EN
        ops_done++;
`endif
        check("idle_req_ready", {31'd0, req_ready_o}, 32'd1);
        check("idle_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        check("idle_x_o_hold", {24'd0, x_o}, {24'd0, x});
        tick();
        check("idle_flags", {30'd0, flag_z_o, flag_c_o}, {30'd0, flag_z_m, flag_c_m});
    endtask

    task automatic check_reset_state(input string name);
        check({name, "_req_ready"}, {31'd0, req_ready_o}, 32'd1);
        check({name, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd0);
        check({name, "_regs"}, {x_o, y_o, rsp_r_o, 5'd0, op_o}, 32'd0);
        check({name, "_flags"}, {28'd0, rsp_fz_o, rsp_fc_o, flag_z_o, flag_c_o}, 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{x: 8'd1,   y: 8'd1,   op: 3'd0, hold: 0, r: 8'd2,   fz: 1'b0, fc: 1'b0};
        vecs[1] = '{x: 8'd7,   y: 8'd3,   op: 3'd1, hold: 0, r: 8'd4,   fz: 1'b0, fc: 1'b0};
        vecs[2] = '{x: 8'd2,   y: 8'd2,   op: 3'd1, hold: 1, r: 8'd0,   fz: 1'b1, fc: 1'b0};
        vecs[3] = '{x: 8'd3,   y: 8'd4,   op: 3'd1, hold: 0, r: 8'd255, fz: 1'b0, fc: 1'b1};
        vecs[4] = '{x: 8'd200, y: 8'd100, op: 3'd0, hold: 5, r: 8'd44,  fz: 1'b0, fc: 1'b1};
        vecs[5] = '{x: 8'd5,   y: 8'd9,   op: 3'd5, hold: 2, r: 8'd5,   fz: 1'b0, fc: 1'b0};
        vecs[6] = '{x: 8'd0,   y: 8'd0,   op: 3'd0, hold: 0, r: 8'd0,   fz: 1'b1, fc: 1'b0};
        vecs[7] = '{x: 8'd255, y: 8'd1,   op: 3'd0, hold: 0, r: 8'd0,   fz: 1'b1, fc: 1'b1};

        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b0;
        req_x_i     = '0;
        req_y_i     = '0;
        req_op_i    = '0;
        tick();
        tick();
        rst_i = 1'b0;
        check_reset_state("reset");

        foreach (vecs[i]) begin
            do_op(vecs[i].x, vecs[i].y, vecs[i].op, vecs[i].hold,
                  vecs[i].r, vecs[i].fz, vecs[i].fc);
        end
        // Last vector left both flags set; they must survive several idle cycles.
        repeat (3) tick();
        check("flags_persist_idle", {30'd0, flag_z_o, flag_c_o}, 32'd3);

        // Reset while in EXEC aborts the operation.
        req_valid_i = 1'b1;
        req_x_i     = 8'd10;
        req_y_i     = 8'd20;
        req_op_i    = 3'd0;
        tick();
        req_valid_i = 1'b0;
        rst_i       = 1'b1;
        tick();
        rst_i = 1'b0;
        flag_z_m = 1'b0;
        flag_c_m = 1'b0;
`ifdef ALU_SEQ_OPCNT_EN
        ops_done = 0;
`endif
        check_reset_state("rst_exec");
        for (int i = 0; i < 4; i++) begin
            tick();
            check("rst_exec_no_rsp", {31'd0, rsp_valid_o}, 32'd0);
        end

        // Reset wins over a simultaneous request.
        req_valid_i = 1'b1;
        req_x_i     = 8'd9;
        rst_i       = 1'b1;
        tick();
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        check_reset_state("rst_vs_req");

        // Reset wins over a response handshake in RESP.
        req_valid_i = 1'b1;
        req_x_i     = 8'd3;
        req_y_i     = 8'd4;
        req_op_i    = 3'd1;
        tick();
        req_valid_i = 1'b0;
        tick();
        check("rst_resp_pre_valid", {31'd0, rsp_valid_o}, 32'd1);
        rsp_ready_i = 1'b1;
        rst_i       = 1'b1;
        tick();
        rst_i       = 1'b0;
        rsp_ready_i = 1'b0;
        check_reset_state("rst_resp");

        for (int n = 0; n < 40; n++) begin
            logic [W-1:0] x, y, er;
            logic [2:0]   op;
            logic         efz, efc;
            x  = W'($urandom);
            y  = W'($urandom);
            op = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(2, 7)) :
                                               3'($urandom_range(0, 1));
            ref_model(int'(x), int'(y), int'(op), er, efz, efc);
            do_op(x, y, op, $urandom_range(0, 3), er, efz, efc);
        end

`ifdef ALU_SEQ_OPCNT_EN
        check("opcnt", {16'd0, opcnt_o}, 32'(ops_done % 65536));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
